alu_writeback_stage: RTL and testbench

//   Sits directly downstream of the ALU. Buffers each ALU result in a 2-entry in-order queue for

---
 rtl/alu_writeback_stage.sv | 120 ++++++++++++
 tb/tb_alu_writeback_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback_stage.sv
// ALU write-back stage: 2-entry in-order result queue with valid/ready handshakes,
// architectural N/Z/C/V flag register committed at retire, and branch-condition evaluation.
module alu_writeback_stage #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_result,
  input  logic [REG_ADDR_W-1:0] in_dest,
  input  logic                  in_write_reg,
  input  logic                  in_write_flags,
  input  logic [3:0]            in_flags,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [REG_ADDR_W-1:0] out_dest,
  output logic                  out_write_reg,
  output logic [3:0]            flags_q,
  output logic                  flags_pending,
  input  logic [2:0]            br_cond_sel,
  output logic                  br_taken
);

  logic [DATA_W-1:0]     r_data  [2];
  logic [REG_ADDR_W-1:0] r_dest  [2];
  logic [1:0]            r_wr;
  logic [1:0]            r_wf;
  logic [3:0]            r_fl    [2];
  logic [1:0]            r_count;
  logic                  r_head;
  logic [3:0]            r_flags;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_tail;
  logic [1:0]            w_slot_valid;

  assign in_ready  = (r_count < 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  // With one entry queued the free slot is the one after the head.
  assign w_tail    = r_head ^ r_count[0];

  assign out_data      = r_data[r_head];
  assign out_dest      = r_dest[r_head];
  assign out_write_reg = r_wr[r_head];
  assign flags_q       = r_flags;

  // Slot occupancy from the registered count and head pointer.
  always_comb begin
    w_slot_valid = 2'b00;
    case (r_count)
      2'd1:    w_slot_valid = r_head ? 2'b10 : 2'b01;
      2'd2:    w_slot_valid = 2'b11;
      default: w_slot_valid = 2'b00;
    endcase
  end

  assign flags_pending = |(w_slot_valid & r_wf);

  // Queue storage, pointers and in-order flag commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        r_data[i] <= '0;
        r_dest[i] <= '0;
        r_fl[i]   <= 4'b0000;
      end
      r_wr    <= 2'b00;
      r_wf    <= 2'b00;
      r_count <= 2'd0;
      r_head  <= 1'b0;
      r_flags <= 4'b0000;
    end else if (flush) begin
      r_count <= 2'd0;
      r_head  <= 1'b0;
    end else begin
      if (w_push) begin
        r_data[w_tail] <= in_result;
        r_dest[w_tail] <= in_dest;
        r_wr[w_tail]   <= in_write_reg;
        r_wf[w_tail]   <= in_write_flags;
        r_fl[w_tail]   <= in_flags;
      end
      if (w_pop) begin
        r_head <= ~r_head;
        if (r_wf[r_head]) begin
          r_flags <= r_fl[r_head];
        end
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Branch condition decode from committed flags {N,Z,C,V}.
  always_comb begin
    br_taken = 1'b0;
    case (br_cond_sel)
      3'b000:  br_taken = 1'b0;
      3'b001:  br_taken = 1'b1;
      3'b010:  br_taken = r_flags[2];
      3'b011:  br_taken = ~r_flags[2];
      3'b100:  br_taken = ~r_flags[2] & ~(r_flags[3] ^ r_flags[0]);
      3'b101:  br_taken = ~(r_flags[3] ^ r_flags[0]);
      3'b110:  br_taken = r_flags[1];
      3'b111:  br_taken = r_flags[0];
      default: br_taken = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed table-driven bench for alu_writeback_stage with hand-written reset/latency sequences.
module tb_alu_writeback_stage;

  logic       clk;
  logic       reset_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_result;
  logic [1:0] in_dest;
  logic       in_write_reg;
  logic       in_write_flags;
  logic [3:0] in_flags;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_dest;
  logic       out_write_reg;
  logic [3:0] flags_q;
  logic       flags_pending;
  logic [2:0] br_cond_sel;
  logic       br_taken;

  int n_tests;
  int n_fail;

  alu_writeback_stage #(.DATA_W(8), .REG_ADDR_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_dest(in_dest),
    .in_write_reg(in_write_reg), .in_write_flags(in_write_flags), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_dest(out_dest),
    .out_write_reg(out_write_reg), .flags_q(flags_q), .flags_pending(flags_pending),
    .br_cond_sel(br_cond_sel), .br_taken(br_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [7:0] res;
    logic [1:0] dest;
    logic       wr;
    logic       wf;
    logic [3:0] fl;
    logic       ordy;
    logic       fsh;
    logic [2:0] sel;
    logic       e_rdy;
    logic       e_ov;
    logic [7:0] e_data;
    logic [1:0] e_dest;
    logic       e_wr;
    logic [3:0] e_fq;
    logic       e_pend;
    logic       e_br;
  } vec_t;

  vec_t vecs [24];

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    in_valid       = t.v;
    in_result      = t.res;
    in_dest        = t.dest;
    in_write_reg   = t.wr;
    in_write_flags = t.wf;
    in_flags       = t.fl;
    out_ready      = t.ordy;
    flush          = t.fsh;
    br_cond_sel    = t.sel;
  endtask

  task automatic chk_reset_vals(input int idx);
    chk("rst_out_valid", idx, {7'd0, out_valid}, 8'd0);
    chk("rst_out_data", idx, out_data, 8'd0);
    chk("rst_out_dest", idx, {6'd0, out_dest}, 8'd0);
    chk("rst_out_wr", idx, {7'd0, out_write_reg}, 8'd0);
    chk("rst_flags_q", idx, {4'd0, flags_q}, 8'd0);
    chk("rst_pending", idx, {7'd0, flags_pending}, 8'd0);
    chk("rst_in_ready", idx, {7'd0, in_ready}, 8'd1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    //            v     res    dest  wr    wf    fl       ordy  fsh   sel     rdy   ov    data   dest  wr    fq       pend  br
    vecs[0]  = '{1'b1, 8'h3C, 2'd2, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 3'b001, 1'b1, 1'b1, 8'h3C, 2'd2, 1'b1, 4'b0000, 1'b1, 1'b1};
    vecs[1]  = '{1'b1, 8'h11, 2'd1, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 8'h3C, 2'd2, 1'b1, 4'b0000, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 8'h22, 2'd3, 1'b1, 1'b1, 4'b0100, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1, 8'h3C, 2'd2, 1'b1, 4'b0000, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 3'b011, 1'b1, 1'b1, 8'h11, 2'd1, 1'b0, 4'b0000, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 8'hAA, 2'd0, 1'b1, 1'b1, 4'b0100, 1'b0, 1'b0, 3'b010, 1'b1, 1'b1, 8'hAA, 2'd0, 1'b1, 4'b0000, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 4'b0100, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 3'b011, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 4'b0100, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'h01, 2'd1, 1'b1, 1'b1, 4'b1000, 1'b0, 1'b0, 3'b110, 1'b1, 1'b1, 8'h01, 2'd1, 1'b1, 4'b0100, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 8'h02, 2'd2, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0, 3'b111, 1'b1, 1'b1, 8'h02, 2'd2, 1'b0, 4'b1000, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 8'h03, 2'd3, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 3'b110, 1'b1, 1'b1, 8'h03, 2'd3, 1'b1, 4'b0010, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 8'h04, 2'd0, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b0, 3'b010, 1'b1, 1'b1, 8'h04, 2'd0, 1'b1, 4'b0010, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 8'h05, 2'd1, 1'b0, 1'b1, 4'b1001, 1'b1, 1'b0, 3'b111, 1'b1, 1'b1, 8'h05, 2'd1, 1'b0, 4'b0001, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 3'b100, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 4'b1001, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 3'b101, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 4'b1001, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 8'h06, 2'd2, 1'b1, 1'b1, 4'b1000, 1'b0, 1'b0, 3'b100, 1'b1, 1'b1, 8'h06, 2'd2, 1'b1, 4'b1001, 1'b1, 1'b1};
    vecs[16] = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 3'b100, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 4'b1000, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 3'b101, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 4'b1000, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 8'h07, 2'd3, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0, 3'b001, 1'b1, 1'b1, 8'h07, 2'd3, 1'b1, 4'b1000, 1'b1, 1'b1};
    vecs[19] = '{1'b1, 8'h08, 2'd0, 1'b0, 1'b1, 4'b0011, 1'b0, 1'b0, 3'b001, 1'b0, 1'b1, 8'h07, 2'd3, 1'b1, 4'b1000, 1'b1, 1'b1};
    vecs[20] = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 3'b010, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 4'b1000, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 8'h09, 2'd2, 1'b1, 1'b1, 4'b0101, 1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 4'b1000, 1'b0, 1'b1};
    vecs[22] = '{1'b1, 8'h0A, 2'd1, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 8'h0A, 2'd1, 1'b1, 4'b1000, 1'b0, 1'b0};
    vecs[23] = '{1'b1, 8'h0B, 2'd2, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 3'b110, 1'b0, 1'b1, 8'h0A, 2'd1, 1'b1, 4'b1000, 1'b1, 1'b0};

    reset_n        = 1'b0;
    flush          = 1'b0;
    in_valid       = 1'b0;
    in_result      = 8'h00;
    in_dest        = 2'd0;
    in_write_reg   = 1'b0;
    in_write_flags = 1'b0;
    in_flags       = 4'b0000;
    out_ready      = 1'b0;
    br_cond_sel    = 3'b000;
    #1;
    chk_reset_vals(-1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      chk("in_ready", i, {7'd0, in_ready}, {7'd0, vecs[i].e_rdy});
      chk("out_valid", i, {7'd0, out_valid}, {7'd0, vecs[i].e_ov});
      if (vecs[i].e_ov) begin
        chk("out_data", i, out_data, vecs[i].e_data);
        chk("out_dest", i, {6'd0, out_dest}, {6'd0, vecs[i].e_dest});
        chk("out_write_reg", i, {7'd0, out_write_reg}, {7'd0, vecs[i].e_wr});
      end
      chk("flags_q", i, {4'd0, flags_q}, {4'd0, vecs[i].e_fq});
      chk("flags_pending", i, {7'd0, flags_pending}, {7'd0, vecs[i].e_pend});
      chk("br_taken", i, {7'd0, br_taken}, {7'd0, vecs[i].e_br});
    end

    // Reset asserted with two entries queued: outputs clear without a clock edge.
    @(negedge clk);
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    br_cond_sel = 3'b101;
    #1;
    chk("pre_rst_out_valid", 100, {7'd0, out_valid}, 8'd1);
    reset_n = 1'b0;
    #1;
    chk_reset_vals(100);
    chk("rst_br_ge", 100, {7'd0, br_taken}, 8'd1);

    // After release, a push is visible only after the next edge.
    @(negedge clk);
    reset_n        = 1'b1;
    @(negedge clk);
    in_valid       = 1'b1;
    in_result      = 8'h5A;
    in_dest        = 2'd3;
    in_write_reg   = 1'b1;
    in_write_flags = 1'b0;
    in_flags       = 4'b1111;
    #1;
    chk("no_bypass_valid", 101, {7'd0, out_valid}, 8'd0);
    @(posedge clk);
    #1;
    chk("lat_out_valid", 101, {7'd0, out_valid}, 8'd1);
    chk("lat_out_data", 101, out_data, 8'h5A);
    chk("lat_out_dest", 101, {6'd0, out_dest}, 8'd3);
    chk("lat_pending", 101, {7'd0, flags_pending}, 8'd0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("nowf_flags_q", 102, {4'd0, flags_q}, 8'd0);
    chk("drain_valid", 102, {7'd0, out_valid}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
